// File: rtl/multicycle_control.sv
// Control FSM for the RV32I multicycle datapath: sequences fetch, decode, execute,
// memory access and writeback, and drives every datapath select and enable.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr,
    output logic [3:0] state
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] alu_funct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Subtract only for R-type; I-type funct7b5 is part of the immediate.
    always_comb begin
        case (funct3)
            3'b000:  alu_funct = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d       = S_FETCH;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      illegal_instr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
                state_d    = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues its expected
// output vector; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;

    // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal}
    wire [20:0] act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr};

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            total++;
            if (act === mon_e.v) passed++;
            else $display("FAIL %s: got %h want %h", mon_e.tag, act, mon_e.v);
        end
    end

    task automatic push(input string tag, input logic [3:0] st,
                        input logic pcw, adr, mw, irw, rw,
                        input logic [1:0] rs, sa, sbv, input logic [2:0] alu,
                        input logic [1:0] imm, input logic ill);
        exp_t e;
        e.tag = tag;
        e.v   = {st, pcw, adr, mw, irw, rw, rs, sa, sbv, alu, imm, ill};
        sb.push_back(e);
    endtask

    task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, z, mr, input logic [3:0] st,
                       input logic pcw, adr, mw, irw, rw,
                       input logic [1:0] rs, sa, sbv, input logic [2:0] alu,
                       input logic [1:0] imm, input logic ill);
        @(posedge clk); #1;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr;
        push(tag, st, pcw, adr, mw, irw, rw, rs, sa, sbv, alu, imm, ill);
    endtask

    task automatic fe(input string tag, input logic [6:0] o, input logic mr, input logic [1:0] imm);
        cyc(tag, o, 3'd0, 1'b0, 1'b0, mr, 4'd0, mr, 0, 0, mr, 0, 2'd2, 2'd0, 2'd2, 3'd0, imm, 0);
    endtask

    task automatic de(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic [1:0] imm, input logic ill);
        cyc(tag, o, f3, f7, z, 1'b1, 4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, imm, ill);
    endtask

    task automatic alu_op(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] alu);
        logic [3:0] st;
        st = (o == RT) ? 4'd6 : 4'd7;
        fe({tag, "-f"}, o, 1'b1, 2'd0);
        de({tag, "-d"}, o, f3, f7, 1'b0, 2'd0, 1'b0);
        cyc({tag, "-x"}, o, f3, f7, 0, 1, st, 0, 0, 0, 0, 0, 2'd0, 2'd2,
            (o == RT) ? 2'd0 : 2'd1, alu, 2'd0, 0);
        cyc({tag, "-wb"}, o, f3, f7, 0, 1, 4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0);
    endtask

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // lw stalled in MEMREAD, then abandoned by an asynchronous reset
        fe("pre-f", LW, 1'b1, 2'd0);
        de("pre-d", LW, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc("pre-a", LW, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0);
        cyc("pre-r", LW, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0);
        @(posedge clk); #1;
        push("async-rst", 4'd0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push("rst-release", 4'd0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 2'd0, 0);
        fe("post-rst", LW, 1'b0, 2'd0);

        // lw, mem_ready high
        fe("lw-f", LW, 1'b1, 2'd0);
        de("lw-d", LW, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        cyc("lw-a", LW, 0, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0);
        cyc("lw-r", LW, 0, 0, 0, 1, 4'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0);
        cyc("lw-wb", LW, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 2'd0, 0);

        // sw with two stall cycles in MEMWRITE
        fe("sw-f", SW, 1'b1, 2'd1);
        de("sw-d", SW, 3'd2, 1'b0, 1'b0, 2'd1, 1'b0);
        cyc("sw-a", SW, 2, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd1, 0);
        cyc("sw-w0", SW, 2, 0, 0, 0, 4'd5, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 0);
        cyc("sw-w1", SW, 2, 0, 0, 0, 4'd5, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 0);
        cyc("sw-w2", SW, 2, 0, 0, 1, 4'd5, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 0);

        // ALU decode
        alu_op("r-sub", RT, 3'd0, 1'b1, 3'b001);
        alu_op("i-add", IT, 3'd0, 1'b1, 3'b000);
        alu_op("r-and", RT, 3'd7, 1'b0, 3'b010);
        alu_op("i-or",  IT, 3'd6, 1'b0, 3'b011);
        alu_op("i-slt", IT, 3'd2, 1'b0, 3'b101);
        alu_op("r-xor", RT, 3'd4, 1'b0, 3'b000);

        // beq taken / not taken
        fe("beq1-f", BEQ, 1'b1, 2'd2);
        de("beq1-d", BEQ, 3'd0, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc("beq1-b", BEQ, 0, 0, 1, 1, 4'd9, 1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd2, 0);
        fe("beq0-f", BEQ, 1'b1, 2'd2);
        de("beq0-d", BEQ, 3'd0, 1'b0, 1'b1, 2'd2, 1'b0);
        cyc("beq0-b", BEQ, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd2, 0);

        // jal
        fe("jal-f", JAL, 1'b1, 2'd3);
        de("jal-d", JAL, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0);
        cyc("jal-j", JAL, 0, 0, 0, 1, 4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 2'd3, 0);
        cyc("jal-wb", JAL, 0, 0, 0, 1, 4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd3, 0);

        // illegal opcode after a fetch stall
        fe("bad-stall", BAD, 1'b0, 2'd0);
        fe("bad-f", BAD, 1'b1, 2'd0);
        de("bad-d", BAD, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        fe("bad-next", BAD, 1'b0, 2'd0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
